data_memory_dp_arb: RTL

- Parametrised successor to the fixed 4096x32 dual-port data memory. Width, depth and read latency are configurable.
- Port A (CPU) and port B (AXI bridge) use req/ready handshakes with a response-valid strobe.
- Same-address collisions are arbitrated, with a starvation guard and a collision counter.
- Out-of-range accesses are flagged.
- Sits between the pipeline/AXI bridge and the backing BRAM array in riscv_cpu_top.

---
 rtl/mem_pkg.sv | 15 +
 rtl/data_memory_dp_arb_if.sv | 29 ++
 rtl/bram_tdp_core.sv | 50 +++++
 rtl/data_memory_dp_arb.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the dual-port data memory: latency options, read-during-write
// encoding and the SoC default geometry.
package mem_pkg;

  localparam int unsigned RD_LAT_1 = 1;
  localparam int unsigned RD_LAT_2 = 2;

  localparam int unsigned RD_OLD = 0;
  localparam int unsigned RD_NEW = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DEPTH  = 4096;

endpackage

// File: rtl/data_memory_dp_arb_if.sv
// One memory access port: req/ready handshake plus response strobe, data and error.
interface data_memory_dp_arb_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rvalid, rdata, err
  );

endinterface

// File: rtl/bram_tdp_core.sv
// Raw true-dual-port byte-enable array with registered reads; no arbitration or range checks.
module bram_tdp_core
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WRITE_FIRST = RD_OLD
) (
  input  logic                clk,
  input  logic                a_en,
  input  logic [DATA_W/8-1:0] a_wbe,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_en,
  input  logic [DATA_W/8-1:0] b_wbe,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Reads happen on every enabled access; on a write the captured word is internal only.
  always_ff @(posedge clk) begin
    if (a_en) begin
      if (|a_wbe) mem[a_addr] <= merge(mem[a_addr], a_wdata, a_wbe);
      a_rdata <= (WRITE_FIRST == RD_NEW) ? merge(mem[a_addr], a_wdata, a_wbe) : mem[a_addr];
    end
    if (b_en) begin
      if (|b_wbe) mem[b_addr] <= merge(mem[b_addr], b_wdata, b_wbe);
      b_rdata <= (WRITE_FIRST == RD_NEW) ? merge(mem[b_addr], b_wdata, b_wbe) : mem[b_addr];
    end
  end

endmodule

// File: rtl/data_memory_dp_arb.sv
// Dual-port data memory front end: same-address arbitration with a port-B starvation guard,
// range checking, configurable read latency and a saturating collision counter.
module data_memory_dp_arb
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned RD_LATENCY  = RD_LAT_1,
  parameter int unsigned WRITE_FIRST = RD_OLD,
  parameter int unsigned MAX_STALL   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_memory_dp_arb_if.slave  a,
  data_memory_dp_arb_if.slave  b,
  input  logic                 coll_clr,
  output logic [15:0]          coll_cnt
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned STALL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  if (!(RD_LATENCY == RD_LAT_1 || RD_LATENCY == RD_LAT_2)) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end
  if ((DATA_W % 8) != 0 || DEPTH > (2 ** ADDR_W)) begin : g_bad_geometry
    $error("DATA_W must be a multiple of 8 and DEPTH must fit in ADDR_W");
  end

  logic              req   [2];
  logic              we    [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic [NB-1:0]     wstrb [2];
  logic              ready [2];
  logic              acc   [2];
  logic              inr   [2];
  logic              rvalid [2];
  logic              err    [2];
  logic [DATA_W-1:0] rdata      [2];
  logic [DATA_W-1:0] core_rdata [2];

  logic               coll;
  logic               stall_win;
  logic [STALL_W-1:0] stall_q;

  assign req[0]   = a.req;    assign req[1]   = b.req;
  assign we[0]    = a.we;     assign we[1]    = b.we;
  assign addr[0]  = a.addr;   assign addr[1]  = b.addr;
  assign wdata[0] = a.wdata;  assign wdata[1] = b.wdata;
  assign wstrb[0] = a.wstrb;  assign wstrb[1] = b.wstrb;

  assign a.ready  = ready[0];  assign b.ready  = ready[1];
  assign a.rvalid = rvalid[0]; assign b.rvalid = rvalid[1];
  assign a.rdata  = rdata[0];  assign b.rdata  = rdata[1];
  assign a.err    = err[0];    assign b.err    = err[1];

  // Two reads of one word never conflict; anything involving a write does.
  always_comb begin
    coll      = req[0] && req[1] && (addr[0] == addr[1]) && (we[0] || we[1]);
    stall_win = (stall_q == STALL_MAX);
    ready[0]  = rst_n && !(coll && stall_win);
    ready[1]  = rst_n && !(coll && !stall_win);
    for (int p = 0; p < 2; p++) begin
      acc[p] = req[p] && ready[p];
      inr[p] = 32'(addr[p]) < DEPTH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      coll_cnt <= '0;
    end else begin
      stall_q <= (coll && !stall_win) ? stall_q + 1'b1 : '0;
      if (coll_clr) begin
        coll_cnt <= '0;
      end else if (coll && coll_cnt != 16'hFFFF) begin
        coll_cnt <= coll_cnt + 16'd1;
      end
    end
  end

  bram_tdp_core #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_core (
    .clk     (clk),
    .a_en    (acc[0] && inr[0]),
    .a_wbe   (we[0] ? wstrb[0] : '0),
    .a_addr  (addr[0]),
    .a_wdata (wdata[0]),
    .a_rdata (core_rdata[0]),
    .b_en    (acc[1] && inr[1]),
    .b_wbe   (we[1] ? wstrb[1] : '0),
    .b_addr  (addr[1]),
    .b_wdata (wdata[1]),
    .b_rdata (core_rdata[1])
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              rv1_q;
    logic              err1_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] stage_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv1_q  <= 1'b0;
        err1_q <= 1'b0;
      end else begin
        rv1_q  <= acc[p] && !we[p];
        err1_q <= acc[p] && !inr[p];
      end
    end

    // Out-of-range reads return zero; idle and write cycles keep the last response.
    assign stage_d = rv1_q ? (err1_q ? '0 : core_rdata[p]) : hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= '0;
      else        hold_q <= stage_d;
    end

    if (RD_LATENCY == RD_LAT_2) begin : g_lat2
      logic rv2_q;
      logic err2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rv2_q  <= 1'b0;
          err2_q <= 1'b0;
        end else begin
          rv2_q  <= rv1_q;
          err2_q <= err1_q;
        end
      end
      assign rvalid[p] = rv2_q;
      assign err[p]    = err2_q;
      assign rdata[p]  = hold_q;
    end else begin : g_lat1
      assign rvalid[p] = rv1_q;
      assign err[p]    = err1_q;
      assign rdata[p]  = stage_d;
    end
  end

endmodule
